// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings, FSM state,
// byte-enable and load-extension helpers. Split state exists only with DMEM_MISALIGN_SPLIT_EN.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } lsu_state_e;
`endif

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Lane mask over a little-endian word pair: [3:0] first word, [7:4] following word.
    function automatic logic [7:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] base;
        case (f3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] res;
        case (f3)
            F3_B:    res = {{24{raw[7]}}, raw[7:0]};
            F3_H:    res = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   res = {24'b0, raw[7:0]};
            F3_HU:   res = {16'b0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a load/store requester and data_mem_lsu.
interface data_mem_lsu_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;
    logic        read_valid;
    logic        access_fault;

    modport master (
        output mem_read, mem_write, funct3, address, write_data,
        input  ready, read_data, read_valid, access_fault
    );

    modport slave (
        input  mem_read, mem_write, funct3, address, write_data,
        output ready, read_data, read_valid, access_fault
    );
endinterface

// File: rtl/data_mem_bank.sv
// DEPTH x 32 data array with per-byte synchronous write and a registered read port.
// Contents are not affected by reset.
module data_mem_bank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [3:0]       wr_be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin : p_array
        if (wr_be[0]) mem[idx][7:0]   <= wdata[7:0];
        if (wr_be[1]) mem[idx][15:8]  <= wdata[15:8];
        if (wr_be[2]) mem[idx][23:16] <= wdata[23:16];
        if (wr_be[3]) mem[idx][31:24] <= wdata[31:24];
        if (rd_en)    rdata           <= mem[idx];
    end
endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store unit over a word-addressed data bank: sizing, extension and fault pulses.
// Defining DMEM_MISALIGN_SPLIT_EN turns misaligned accesses into two-cycle split accesses.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    data_mem_lsu_if.slave bus
);
    logic             is_store_c;
    logic             accept_c;
    logic             misalign_c;
    logic             bad_f3_c;
    logic             fault_c;
    logic [1:0]       off_c;
    logic [IDX_W-1:0] idx_c;
    logic [7:0]       be_pair_c;
    logic [63:0]      wdata_pair_c;

    logic             rd_en_c;
    logic [3:0]       wr_be_c;
    logic [IDX_W-1:0] bank_idx_c;
    logic [31:0]      bank_wdata_c;
    logic [31:0]      bank_rdata;

    logic             read_valid_q;
    logic             access_fault_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      hold_q;
    logic [63:0]      pair_c;
    logic [31:0]      read_data_c;
    logic             unused_c;

`ifdef DMEM_MISALIGN_SPLIT_EN
    lsu_state_e       state_q;
    logic [IDX_W-1:0] hi_idx_q;
    logic [3:0]       hi_be_q;
    logic [31:0]      hi_data_q;
    logic             hi_store_q;
    logic             split_q;
    logic [31:0]      lo_word_q;
`endif

    // Request decode; stores win over loads when both are raised.
    assign is_store_c   = bus.mem_write;
    assign off_c        = bus.address[1:0];
    assign idx_c        = bus.address[IDX_W+1:2];
    assign misalign_c   = is_misaligned(bus.funct3, off_c);
    assign bad_f3_c     = is_store_c ? !store_f3_ok(bus.funct3) : !load_f3_ok(bus.funct3);
    assign be_pair_c    = byte_enable(bus.funct3, off_c);
    assign wdata_pair_c = {32'b0, bus.write_data} << {off_c, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign bus.ready = (state_q == ST_IDLE);
    assign fault_c   = bad_f3_c;
    assign unused_c  = ^bus.address[31:IDX_W+2];
`else
    assign bus.ready = 1'b1;
    assign fault_c   = bad_f3_c | misalign_c;
    assign unused_c  = ^{bus.address[31:IDX_W+2], be_pair_c[7:4], wdata_pair_c[63:32]};
`endif

    assign accept_c = bus.ready & (bus.mem_read | bus.mem_write);

    // Bank port: the second half of a split access owns it during SPLIT.
    always_comb begin : p_bank_ctrl
        rd_en_c      = 1'b0;
        wr_be_c      = 4'b0000;
        bank_idx_c   = idx_c;
        bank_wdata_c = wdata_pair_c[31:0];
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == ST_SPLIT) begin
            bank_idx_c   = hi_idx_q;
            bank_wdata_c = hi_data_q;
            if (hi_store_q) wr_be_c = hi_be_q;
            else            rd_en_c = 1'b1;
        end else
`endif
        if (accept_c && !fault_c) begin
            if (is_store_c) wr_be_c = be_pair_c[3:0];
            else            rd_en_c = 1'b1;
        end
    end

    data_mem_bank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk   (clk),
        .rd_en (rd_en_c),
        .wr_be (wr_be_c),
        .idx   (bank_idx_c),
        .wdata (bank_wdata_c),
        .rdata (bank_rdata)
    );

    // Load formatting is valid only in the read_valid cycle; otherwise the last result is held.
`ifdef DMEM_MISALIGN_SPLIT_EN
    assign pair_c = split_q ? {bank_rdata, lo_word_q} : {32'b0, bank_rdata};
`else
    assign pair_c = {32'b0, bank_rdata};
`endif
    assign read_data_c      = load_extend(f3_q, 32'(pair_c >> {off_q, 3'b000}));
    assign bus.read_data    = read_valid_q ? read_data_c : hold_q;
    assign bus.read_valid   = read_valid_q;
    assign bus.access_fault = access_fault_q;

    always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
        if (!rst_n) begin
            read_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            hold_q         <= 32'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            state_q        <= ST_IDLE;
            hi_idx_q       <= '0;
            hi_be_q        <= 4'b0000;
            hi_data_q      <= 32'b0;
            hi_store_q     <= 1'b0;
            split_q        <= 1'b0;
            lo_word_q      <= 32'b0;
`endif
        end else begin
            read_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
            if (read_valid_q) hold_q <= read_data_c;
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (state_q == ST_SPLIT) begin
                state_q      <= ST_IDLE;
                lo_word_q    <= bank_rdata;
                read_valid_q <= !hi_store_q;
            end else
`endif
            if (accept_c) begin
                f3_q  <= bus.funct3;
                off_q <= off_c;
                if (fault_c) begin
                    access_fault_q <= 1'b1;
`ifdef DMEM_MISALIGN_SPLIT_EN
                end else if (misalign_c) begin
                    state_q    <= ST_SPLIT;
                    hi_idx_q   <= idx_c + IDX_W'(1);
                    hi_be_q    <= be_pair_c[7:4];
                    hi_data_q  <= wdata_pair_c[63:32];
                    hi_store_q <= is_store_c;
                    split_q    <= 1'b1;
                end else begin
                    split_q      <= 1'b0;
                    read_valid_q <= !is_store_c;
`else
                end else begin
                    read_valid_q <= !is_store_c;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu; split-mode steps are selected by DMEM_MISALIGN_SPLIT_EN.
module tb_data_mem_lsu;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    data_mem_lsu_if bus ();

    data_mem_lsu #(.DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.mem_write  = wr;
        bus.mem_read   = rd;
        bus.funct3     = f3;
        bus.address    = a;
        bus.write_data = d;
    endtask

    // Present a request for one cycle; returns at the falling edge of the next cycle.
    task automatic req(input logic wr, input logic rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(wr, rd, f3, a, d);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req(1'b1, 1'b0, f3, a, d);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a);
        req(1'b0, 1'b1, f3, a, 32'h0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'h1);
        chk("rst_valid", 32'(bus.read_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fault", 32'(bus.access_fault), 32'h0);
        chk("rst_rdata", bus.read_data, 32'h0);

        st(LW, 32'h10, 32'h1122_3344);
        chk("sw_no_valid", 32'(bus.read_valid), 32'h0);
        ld(LW, 32'h10);
        chk("lw_valid", 32'(bus.read_valid), 32'h1);
        chk("lw_data", bus.read_data, 32'h1122_3344);
        @(negedge clk);
        chk("lw_pulse", 32'(bus.read_valid), 32'h0);
        chk("lw_hold", bus.read_data, 32'h1122_3344);

        st(LB, 32'h13, 32'h0000_0080);
        ld(LB, 32'h13);   chk("lb_sign", bus.read_data, 32'hFFFF_FF80);
        ld(LBU, 32'h13);  chk("lbu_zero", bus.read_data, 32'h0000_0080);
        ld(LW, 32'h10);   chk("sb_word", bus.read_data, 32'h8022_3344);

        st(LH, 32'h12, 32'h1234_BEEF);
        ld(LH, 32'h12);   chk("lh_sign", bus.read_data, 32'hFFFF_BEEF);
        ld(LHU, 32'h12);  chk("lhu_zero", bus.read_data, 32'h0000_BEEF);
        ld(LH, 32'h10);   chk("lh_low", bus.read_data, 32'h0000_3344);

        // Store then load of the same word on consecutive cycles
        @(negedge clk); drive(1'b1, 1'b0, LW, 32'h20, 32'hCAFE_F00D);
        @(negedge clk); drive(1'b0, 1'b1, LW, 32'h20, 32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("b2b_valid", 32'(bus.read_valid), 32'h1);
        chk("b2b_data", bus.read_data, 32'hCAFE_F00D);

        st(LW, 32'hFFFF_F024, 32'h0BAD_BEEF);
        ld(LW, 32'h24);   chk("wrap_lo", bus.read_data, 32'h0BAD_BEEF);
        ld(LW, 32'h1024); chk("wrap_alias", bus.read_data, 32'h0BAD_BEEF);

        ld(3'b011, 32'h10);
        chk("f3_011_fault", 32'(bus.access_fault), 32'h1);
        chk("f3_011_novalid", 32'(bus.read_valid), 32'h0);
        chk("f3_011_hold", bus.read_data, 32'h0BAD_BEEF);
        @(negedge clk);
        chk("fault_pulse", 32'(bus.access_fault), 32'h0);
        ld(3'b111, 32'h10);
        chk("f3_111_fault", 32'(bus.access_fault), 32'h1);

        st(3'b100, 32'h10, 32'hFFFF_FFFF);
        chk("st_f3_fault", 32'(bus.access_fault), 32'h1);
        ld(LW, 32'h10);   chk("st_f3_nochange", bus.read_data, 32'hBEEF_3344);

        req(1'b1, 1'b1, LW, 32'h28, 32'h1234_5678);
        chk("rw_novalid", 32'(bus.read_valid), 32'h0);
        ld(LW, 32'h28);   chk("rw_store", bus.read_data, 32'h1234_5678);

`ifdef DMEM_MISALIGN_SPLIT_EN
        st(LW, 32'h0C, 32'h0);
        st(LW, 32'h10, 32'h0);
        st(LW, 32'h0E, 32'hAABB_CCDD);
        chk("ssw_busy", 32'(bus.ready), 32'h0);
        ld(LW, 32'h0C);   chk("ssw_lo_word", bus.read_data, 32'hCCDD_0000);
        ld(LW, 32'h10);   chk("ssw_hi_word", bus.read_data, 32'h0000_AABB);

        ld(LW, 32'h0E);
        chk("slw_busy", 32'(bus.ready), 32'h0);
        chk("slw_early", 32'(bus.read_valid), 32'h0);
        @(negedge clk);
        chk("slw_valid", 32'(bus.read_valid), 32'h1);
        chk("slw_data", bus.read_data, 32'hAABB_CCDD);
        chk("slw_ready", 32'(bus.ready), 32'h1);

        st(LW, 32'hFFC, 32'h1200_0000);
        st(LW, 32'h000, 32'h0000_00F4);
        ld(LH, 32'hFFF);
        @(negedge clk);
        chk("slh_wrap_valid", 32'(bus.read_valid), 32'h1);
        chk("slh_wrap_data", bus.read_data, 32'hFFFF_F412);

        st(LW, 32'h20, 32'h0);
        st(LW, 32'h24, 32'h0);
        st(LW, 32'h22, 32'h5566_7788);
        chk("rsplit_busy", 32'(bus.ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rsplit_ready", 32'(bus.ready), 32'h1);
        chk("rsplit_valid", 32'(bus.read_valid), 32'h0);
        chk("rsplit_fault", 32'(bus.access_fault), 32'h0);
        chk("rsplit_rdata", bus.read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ld(LW, 32'h20);   chk("rsplit_lo_kept", bus.read_data, 32'h7788_0000);
        ld(LW, 32'h24);   chk("rsplit_hi_none", bus.read_data, 32'h0000_0000);
`else
        st(LW, 32'h00, 32'h0102_0304);
        ld(LW, 32'h02);
        chk("mis_lw_fault", 32'(bus.access_fault), 32'h1);
        chk("mis_lw_novalid", 32'(bus.read_valid), 32'h0);
        st(LW, 32'h02, 32'hFFFF_FFFF);
        chk("mis_sw_fault", 32'(bus.access_fault), 32'h1);
        ld(LW, 32'h00);   chk("mis_sw_nochange", bus.read_data, 32'h0102_0304);
        ld(LH, 32'h01);
        chk("mis_lh_fault", 32'(bus.access_fault), 32'h1);
        ld(LHU, 32'h02);
        chk("al_lhu_valid", 32'(bus.read_valid), 32'h1);
        chk("al_lhu_data", bus.read_data, 32'h0000_0102);
        chk("nosplit_ready", 32'(bus.ready), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter IDX_W, default $clog2(DEPTH), meaning the word-index width; the word index is address[IDX_W+1:2].
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk and rst_n.
REQ-004 Ports, one per line:
 clk  in  1  rising-edge clock.
 rst_n  in  1  asynchronous active-low reset.
 mem_read  in  1  load request, sampled when ready=1.
 mem_write  in  1  store request, sampled when ready=1; has priority over mem_read.
 funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
 address  in  32  byte address.
 write_data  in  32  store data, low bytes used for B/H.
 ready  out  1  request accepted this cycle.
 read_data  out  32  load result, sign- or zero-extended.
 read_valid  out  1  one-cycle pulse qualifying read_data.
 access_fault  out  1  one-cycle pulse for a rejected request.

Function
REQ-005 SHALL ignore address bits above IDX_W+1, so addresses wrap modulo DEPTH*4.
REQ-006 Aligned load accepted in cycle T SHALL drive read_valid=1 and read_data in T+1; read_data SHALL hold until the next read_valid.
REQ-007 Aligned store accepted in T SHALL update only the enabled bytes at the T/T+1 edge; a load accepted in T+1 to the same word SHALL return the new data.
REQ-008 Byte lanes SHALL be selected by address[1:0]; halfword lanes by address[1].
REQ-009 Loads SHALL extend the sign bit for B/H and extend zero for BU/HU.
REQ-010 Misalignment SHALL mean H/HU with address[0]=1, or W with address[1:0]!=00.
REQ-011 funct3 011, 110 or 111 on mem_read, or any funct3 other than 000/001/010 on mem_write, SHALL be rejected: access_fault=1 in T+1, no memory change, no read_valid.
REQ-012 FSM states SHALL be IDLE and SPLIT; ready=1 only in IDLE.
REQ-013 IDLE->SPLIT SHALL occur only on an accepted misaligned access with the split feature compiled in; SPLIT->IDLE SHALL always occur after one cycle.
REQ-014 A split access SHALL use word idx in T and word (idx+1) mod DEPTH in T+1, so idx DEPTH-1 wraps to 0.
REQ-015 A split load SHALL combine bytes little-endian and assert read_valid in T+2.
REQ-016 A split store SHALL write its low-word bytes at the end of T and its high-word bytes at the end of T+1.
REQ-017 With mem_read=mem_write=1, only the store SHALL be performed.
REQ-018 Requests while ready=0 SHALL be ignored; the requester must hold them.

Reset
REQ-019 On rst_n=0, the block SHALL immediately set the FSM to IDLE, read_data=0, read_valid=0 and access_fault=0; ready SHALL be 1 after reset.
REQ-020 Memory contents SHALL NOT be cleared by rst_n; they SHALL be zero at simulation start.
REQ-021 Reset during SPLIT SHALL abandon the second half, keeping any first-half store bytes already written, and produce no read_valid.

Configuration
REQ-022 Macro DMEM_MISALIGN_SPLIT_EN, when defined, SHALL enable two-cycle split handling of misaligned accesses (REQ-013..016).
REQ-023 Without DMEM_MISALIGN_SPLIT_EN, a misaligned access SHALL be rejected as in REQ-011, the SPLIT state SHALL not exist, and ready SHALL be tied to 1.

Structure
REQ-024 Package dmem_pkg SHALL hold the funct3 encoding constants, the FSM state typedef, and the byte-enable and extend helper functions.
REQ-025 Sub-module data_mem_bank SHALL hold the DEPTH x 32 array, with a 4-bit byte-enable synchronous write and a registered read.

Verification
REQ-026 SW 0x11223344 @0x10, then LW @0x10 -> read_valid in the next cycle with read_data=0x11223344.
REQ-027 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; word @0x10 reads 0x80223344.
REQ-028 With split enabled: SW 0xAABBCCDD @0x0E, then LW @0x0E -> ready=0 for one cycle, read_valid at T+2, data 0xAABBCCDD; bytes @0x0E..0x11 = DD,CC,BB,AA.
REQ-029 With split enabled and DEPTH=1024: LH @0xFFF -> bytes taken from word 1023 byte 3 and word 0 byte 0 (wrap).
REQ-030 Without the macro: LW @0x02 -> access_fault pulse, no read_valid; SW @0x02 -> memory unchanged. funct3=011 load -> access_fault.
REQ-031 With split enabled: assert rst_n=0 during the SPLIT cycle of a misaligned SW -> FSM returns to IDLE, first-word bytes written, second-word bytes unchanged, and outputs are zero.
